// File: rtl/mul_pipe_pkg.sv
// Shared types and width helpers for the pipelined floating-point multiplier.
package mul_pipe_pkg;

  typedef enum logic [1:0] {
    RndRne = 2'b00,
    RndRtz = 2'b01,
    RndRup = 2'b10,
    RndRdn = 2'b11
  } rnd_e;

  function automatic int unsigned fp_w(input int unsigned sign_w, input int unsigned expo_w,
                                       input int unsigned mant_w);
    return sign_w + expo_w + mant_w;
  endfunction

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mul_para.sv
// Combinational floating-point multiplier core with four rounding modes.
// Subnormal operands and results flush to signed zero.
module mul_para import mul_pipe_pkg::*; #(
  parameter int unsigned SIGN_W = 1,
  parameter int unsigned EXPO_W = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic [fp_w(SIGN_W, EXPO_W, MANT_W)-1:0] a_i,
  input  logic [fp_w(SIGN_W, EXPO_W, MANT_W)-1:0] b_i,
  input  logic [1:0]                              rnd_i,
  output logic [fp_w(SIGN_W, EXPO_W, MANT_W)-1:0] res_o
);

  localparam int unsigned W  = fp_w(SIGN_W, EXPO_W, MANT_W);
  localparam int unsigned PW = 2 * MANT_W + 2;
  localparam logic [EXPO_W-1:0] EMax = '1;
  localparam logic [EXPO_W+1:0] BiasV = {3'b000, {(EXPO_W - 1){1'b1}}};

  logic              sa, sb, s;
  logic [EXPO_W-1:0] ea, eb;
  logic [MANT_W-1:0] ma, mb, m_norm;
  logic [PW-1:0]     prod;
  logic [EXPO_W+1:0] e_sum, e_norm, e_fin;
  logic [MANT_W:0]   m_rnd;
  logic              g, st, inc, to_inf, ovf, unf;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa = a_i[W-1];
  assign sb = b_i[W-1];
  assign s  = sa ^ sb;
  assign ea = a_i[MANT_W +: EXPO_W];
  assign eb = b_i[MANT_W +: EXPO_W];
  assign ma = a_i[MANT_W-1:0];
  assign mb = b_i[MANT_W-1:0];

  assign a_nan  = (ea == EMax) && (ma != '0);
  assign b_nan  = (eb == EMax) && (mb != '0);
  assign a_inf  = (ea == EMax) && (ma == '0);
  assign b_inf  = (eb == EMax) && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  assign prod  = PW'({1'b1, ma}) * PW'({1'b1, mb});
  assign e_sum = {2'b00, ea} + {2'b00, eb} - BiasV;

  always_comb begin
    m_norm = '0;
    g      = 1'b0;
    st     = 1'b0;
    e_norm = e_sum;
    if (prod[PW-1]) begin
      m_norm = prod[PW-2 -: MANT_W];
      g      = prod[MANT_W];
      st     = |prod[MANT_W-1:0];
      e_norm = e_sum + {{(EXPO_W + 1){1'b0}}, 1'b1};
    end else begin
      m_norm = prod[PW-3 -: MANT_W];
      g      = prod[MANT_W-1];
      st     = |prod[MANT_W-2:0];
    end
  end

  always_comb begin
    inc    = 1'b0;
    to_inf = 1'b0;
    unique case (rnd_e'(rnd_i))
      RndRne: begin
        inc    = g & (st | m_norm[0]);
        to_inf = 1'b1;
      end
      RndRtz: begin
        inc    = 1'b0;
        to_inf = 1'b0;
      end
      RndRup: begin
        inc    = ~s & (g | st);
        to_inf = ~s;
      end
      RndRdn: begin
        inc    = s & (g | st);
        to_inf = s;
      end
      default: begin
        inc    = 1'b0;
        to_inf = 1'b0;
      end
    endcase
  end

  // A rounding carry leaves the mantissa field at zero and bumps the exponent.
  assign m_rnd = {1'b0, m_norm} + {{MANT_W{1'b0}}, inc};
  assign e_fin = m_rnd[MANT_W] ? e_norm + {{(EXPO_W + 1){1'b0}}, 1'b1} : e_norm;
  assign ovf   = ~e_fin[EXPO_W+1] & (e_fin[EXPO_W] | (e_fin[EXPO_W-1:0] == EMax));
  assign unf   = e_fin[EXPO_W+1] | (e_fin == '0);

  always_comb begin
    res_o = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res_o = {SIGN_W'(1'b0), EMax, 1'b1, {(MANT_W - 1){1'b0}}};
    end else if (a_inf || b_inf) begin
      res_o = {SIGN_W'(s), EMax, {MANT_W{1'b0}}};
    end else if (a_zero || b_zero || unf) begin
      res_o = {SIGN_W'(s), {EXPO_W{1'b0}}, {MANT_W{1'b0}}};
    end else if (ovf) begin
      res_o = to_inf ? {SIGN_W'(s), EMax, {MANT_W{1'b0}}}
                     : {SIGN_W'(s), EMax - 1'b1, {MANT_W{1'b1}}};
    end else begin
      res_o = {SIGN_W'(s), e_fin[EXPO_W-1:0], m_rnd[MANT_W-1:0]};
    end
  end

endmodule

// File: rtl/mul_pipe_stage.sv
// Generic valid/ready register slice; ready passes through combinationally.
module mul_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  assign ready_o = ~valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      // Bubbles leave the data untouched so an idle output stays quiet.
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mul_pipe_top.sv
// Stallable pipelined FP multiplier: operand slice, mul_para core, PIPE_STAGES result slices.
// Define MUL_PIPE_TAG_EN to carry a request tag alongside each product.
module mul_pipe_top import mul_pipe_pkg::*; #(
  parameter int unsigned SIGN_W      = 1,
  parameter int unsigned EXPO_W      = 8,
  parameter int unsigned MANT_W      = 23,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [fp_w(SIGN_W, EXPO_W, MANT_W)-1:0] a,
  input  logic [fp_w(SIGN_W, EXPO_W, MANT_W)-1:0] b,
  input  logic [1:0]                              rnd,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [fp_w(SIGN_W, EXPO_W, MANT_W)-1:0] res,
  output logic [occ_w(PIPE_STAGES + 1)-1:0]       occupancy
`ifdef MUL_PIPE_TAG_EN
  ,
  input  logic [TAG_W-1:0]                        in_tag,
  output logic [TAG_W-1:0]                        out_tag
`endif
);

  localparam int unsigned FpW  = fp_w(SIGN_W, EXPO_W, MANT_W);
  localparam int unsigned N    = PIPE_STAGES + 1;
  localparam int unsigned OccW = occ_w(N);
`ifdef MUL_PIPE_TAG_EN
  localparam bit TagEn = 1'b1;
`else
  localparam bit TagEn = 1'b0;
`endif
  localparam int unsigned TagFW = TagEn ? TAG_W : 0;
  localparam int unsigned S0W   = 2 * FpW + 2 + TagFW;
  localparam int unsigned ResW  = FpW + TagFW;

  logic [N-1:0]     vld;
  logic [N:0]       rdy;
  logic [S0W-1:0]   s0_din, s0_dout;
  logic [FpW-1:0]   core_res;
  logic [ResW-1:0]  pd [0:N-1];
  logic [OccW-1:0]  occ_d, occ_q;
  logic             accept, retire;

`ifdef MUL_PIPE_TAG_EN
  assign s0_din = {in_tag, rnd, a, b};
  assign pd[0]  = {s0_dout[S0W-1 -: TAG_W], core_res};
  assign out_tag = pd[N-1][ResW-1 -: TAG_W];
`else
  assign s0_din = {rnd, a, b};
  assign pd[0]  = core_res;
`endif

  assign rdy[N]    = out_ready;
  assign in_ready  = rdy[0];
  assign out_valid = vld[N-1];
  assign res       = pd[N-1][FpW-1:0];

  mul_pipe_stage #(
    .Width(S0W)
  ) u_stage0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(in_valid),
    .ready_o(rdy[0]),
    .data_i (s0_din),
    .valid_o(vld[0]),
    .ready_i(rdy[1]),
    .data_o (s0_dout)
  );

  mul_para #(
    .SIGN_W(SIGN_W),
    .EXPO_W(EXPO_W),
    .MANT_W(MANT_W)
  ) u_core (
    .a_i  (s0_dout[FpW +: FpW]),
    .b_i  (s0_dout[FpW-1:0]),
    .rnd_i(s0_dout[2*FpW +: 2]),
    .res_o(core_res)
  );

  for (genvar k = 1; k < N; k++) begin : g_res_stage
    mul_pipe_stage #(
      .Width(ResW)
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .valid_i(vld[k-1]),
      .ready_o(rdy[k]),
      .data_i (pd[k-1]),
      .valid_o(vld[k]),
      .ready_i(rdy[k+1]),
      .data_o (pd[k])
    );
  end

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    unique case ({accept, retire})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
